// File: rtl/hamming_enc_tx.sv
// hamming_enc_tx: SECDED (Hamming(7,4) plus overall parity) encoder feeding a valid/ready FIFO with a delivery counter.
// Optional macro ERR_INJECT_EN adds inj_en/inj_pos ports that flip one bit of the stored codeword.
module hamming_enc_tx #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       codeword,
   output logic [CNT_W-1:0] tx_count
`ifdef ERR_INJECT_EN
   ,
   input  logic             inj_en,
   input  logic [2:0]       inj_pos
`endif
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] wr_ptr, rd_ptr;
   logic [7:0]  mem [DEPTH];
   logic [6:0]  ham;
   logic [7:0]  enc, stored;
   logic        full, empty, push, pop;
   assign ham = {data_in[3], data_in[2], data_in[1],
                 data_in[1] ^ data_in[2] ^ data_in[3],
                 data_in[0],
                 data_in[0] ^ data_in[2] ^ data_in[3],
                 data_in[0] ^ data_in[1] ^ data_in[3]};
   assign enc = {^ham, ham};
`ifdef ERR_INJECT_EN
   assign stored = inj_en ? enc ^ (8'b1 << inj_pos) : enc;
`else
   assign stored = enc;
`endif
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty     = wr_ptr == rd_ptr;
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && !full;
   assign pop       = !empty && out_ready;
   // gating on empty keeps the output at zero after reset without resetting the storage
   assign codeword  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= stored;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + (AW+1)'(1);
            tx_count <= tx_count + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_hamming_enc_tx.sv
// tb_hamming_enc_tx: queue-based model with per-cycle compare plus directed literal vectors.
module tb_hamming_enc_tx;
   localparam int DEPTH = 4;
   logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
   logic [3:0] data_in = '0;
   logic       in_ready, out_valid, in_ready_w, out_valid_w;
   logic [7:0] codeword, codeword_w, tx_count;
   logic [1:0] tx_count_w;
   logic       inj_en = 0;
   logic [2:0] inj_pos = '0;
   int n_chk = 0, n_fail = 0;
   logic [7:0] q[$];
   int unsigned cnt = 0;

   hamming_enc_tx #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready), .codeword(codeword), .tx_count(tx_count)
`ifdef ERR_INJECT_EN
      , .inj_en(inj_en), .inj_pos(inj_pos)
`endif
   );
   hamming_enc_tx #(.DEPTH(DEPTH), .CNT_W(2)) u_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w), .data_in(data_in),
      .out_valid(out_valid_w), .out_ready(out_ready), .codeword(codeword_w), .tx_count(tx_count_w)
`ifdef ERR_INJECT_EN
      , .inj_en(inj_en), .inj_pos(inj_pos)
`endif
   );

   always #5 clk = ~clk;

   // positional Hamming rule: check bit at position 2^k covers every position with bit k set
   function automatic logic [7:0] model_enc(input logic [3:0] d);
      logic [7:0] c;
      int dp[4] = '{3, 5, 6, 7};
      c = '0;
      for (int i = 0; i < 4; i++) c[dp[i]-1] = d[i];
      for (int k = 0; k < 3; k++) begin
         logic par;
         par = 0;
         for (int pos = 1; pos < 8; pos++) if (((pos >> k) & 1) == 1 && pos != (1 << k)) par ^= c[pos-1];
         c[(1 << k) - 1] = par;
      end
      c[7] = ^c[6:0];
      return c;
   endfunction

   function automatic int syndrome(input logic [7:0] c);
      int s;
      s = 0;
      for (int pos = 1; pos < 8; pos++) if (c[pos-1]) s ^= pos;
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         cnt = 0;
      end else begin
         logic do_pop, do_push;
         logic [7:0] w;
         do_pop  = q.size() > 0 && out_ready;
         do_push = in_valid && q.size() < DEPTH;
         w = model_enc(data_in);
         if (inj_en) w[inj_pos] = ~w[inj_pos];
         if (do_pop) begin
            void'(q.pop_front());
            cnt++;
         end
         if (do_push) q.push_back(w);
      end
   end

   always @(negedge clk) begin
      chk("m_out_valid", out_valid, q.size() > 0);
      chk("m_in_ready", in_ready, q.size() < DEPTH);
      chk("m_codeword", codeword, q.size() > 0 ? q[0] : 8'h00);
      chk("m_tx_count", tx_count, cnt[7:0]);
      chk("m_tx_count_w", tx_count_w, cnt[1:0]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d);
      in_valid = 1;
      data_in  = d;
      tick();
      in_valid = 0;
   endtask

   initial begin
      logic [3:0] vd[4] = '{4'h0, 4'hB, 4'h1, 4'hF};
      logic [7:0] ve[4] = '{8'h00, 8'h55, 8'h87, 8'hFF};
      logic [7:0] bp[4] = '{8'h87, 8'h99, 8'h1E, 8'hAA};
      repeat (3) tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_codeword", codeword, 8'h00);
      chk("rst_tx_count", tx_count, 0);
      rst_n = 1;
      tick();
      chk("rst_in_ready", in_ready, 1);
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         chk("model_enc", model_enc(vd[i]), ve[i]);
         send(vd[i]);
         chk("enc_valid", out_valid, 1);
         chk("enc_codeword", codeword, ve[i]);
      end
      tick();
      out_ready = 0;
      send(4'h7);
      send(4'h8);
      send(4'h9);
      rst_n = 0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_codeword", codeword, 8'h00);
      chk("midrst_tx_count", tx_count, 0);
      tick();
      rst_n = 1;
      tick();
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_discard", out_valid, 0);
      for (int i = 0; i < 4; i++) begin
         chk("bp_in_ready", in_ready, 1);
         send(4'(i + 1));
      end
      chk("bp_full", in_ready, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_codeword", codeword, 8'h87);
         chk("stall_valid", out_valid, 1);
      end
      in_valid  = 1;
      data_in   = 4'h5;
      out_ready = 1;
      chk("full_pop_in_ready", in_ready, 0);
      tick();
      chk("after_pop_in_ready", in_ready, 1);
      chk("after_pop_codeword", codeword, bp[1]);
      tick();
      in_valid = 0;
      chk("order_2", codeword, bp[2]);
      tick();
      chk("order_3", codeword, bp[3]);
      tick();
      chk("bp_tx_count", tx_count, 4);
      chk("no_loss_5", codeword, 8'h2D);
      tick();
      chk("wrap_tx_count", tx_count_w, 1);
      chk("drained", out_valid, 0);
`ifdef ERR_INJECT_EN
      inj_en  = 1;
      inj_pos = 3'd2;
      send(4'hB);
      inj_en = 0;
      chk("inj_codeword", codeword, 8'h51);
      chk("inj_syndrome", syndrome(codeword), 3);
      chk("inj_parity", ^codeword, 1);
`else
      chk("clean_syndrome", syndrome(codeword_w), 0);
`endif
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
